// File: rtl/chaos_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO for the chaos automaton user project.
// Optional even-parity bit (8E1) when CHAOS_UART_TX_PARITY_EN is defined.
module chaos_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

`ifdef CHAOS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [7:0]           shift_q, shift_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
`ifdef CHAOS_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  assign eff_div   = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  // Push is qualified by the registered count only, so a full FIFO refuses even during a pop.
  assign push      = data_valid & ~fifo_full;
  assign pop       = (state_q == S_IDLE) & enable & (count_q != '0);

  assign data_ready = ~fifo_full;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    div_d    = div_q;
    bit_d    = bit_q;
`ifdef CHAOS_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d  = mem_q[rd_ptr_q];
          div_d    = eff_div;
          baud_d   = eff_div - DIV_WIDTH'(1);
`ifdef CHAOS_UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = div_q - DIV_WIDTH'(1);
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_q - DIV_WIDTH'(1);
          if (bit_q == 3'd7) begin
`ifdef CHAOS_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - DIV_WIDTH'(1);
        end
      end
`ifdef CHAOS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          baud_d  = div_q - DIV_WIDTH'(1);
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - DIV_WIDTH'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - DIV_WIDTH'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      baud_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef CHAOS_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef CHAOS_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: doc/chaos_uart_tx.md
Name: chaos_uart_tx

Overview:
- Byte-oriented UART transmitter (8N1) with a small FIFO, for the chaos automaton user project.
- Sends status and readback bytes from the array controller out on a user GPIO pad.
- The testbench UART receiver on mprj_io[6] decodes its output.
- It is the transmit end of the serial link the bench already monitors.

Parameters:
FIFO_DEPTH, 8, number of byte entries in transmit FIFO; power of 2, minimum 2
DIV_WIDTH, 16, width of baud divisor input

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  1 = allow new frames to start
divisor  input  DIV_WIDTH  clock cycles per bit; values 0 and 1 are treated as 2
data_in  input  8  byte to enqueue
data_valid  input  1  enqueue request
data_ready  output  1  FIFO can accept a byte (not full)
tx  output  1  serial line; idles high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the frame being shifted

Behaviour:
- Reset (async, resetn=0):
  - tx=1, busy=0, data_ready=1, fifo_count=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Applies immediately, including mid-frame; the partial frame is discarded.
- FIFO push:
  - A byte is accepted on a rising edge when data_valid=1 and data_ready=1.
  - data_ready = (fifo_count != FIFO_DEPTH), based on the registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: the count is unchanged and both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx=1. If enable=1 and fifo_count>0:
    - pop the head byte into the shift register;
    - latch the effective divisor for the whole frame;
    - go to START. tx falls on the clock edge after the pop decision (1-cycle latency from the qualifying IDLE cycle).
  - START: tx=0 for div cycles, then DATA.
  - DATA: 8 bits, LSB first, each held for div cycles; bit counter 0..7. After bit 7 go to STOP (or PARITY when the optional feature is enabled).
  - STOP: tx=1 for div cycles, then IDLE. Back-to-back frames therefore have exactly one stop bit plus one IDLE cycle between them.
- Baud counter: loads div-1 at the start of each bit, decrements to 0, then advances the bit. Frame length = 10*div + 1 cycles including the IDLE decision cycle.
- Divisor changes mid-frame do not affect the current frame.
- enable deasserted mid-frame: the current frame completes; no new frame starts until enable=1. The FIFO still accepts pushes.
- busy = (state != IDLE) | (fifo_count != 0).
- Arithmetic: divisor treated as unsigned. Effective div = (divisor < 2) ? 2 : divisor.

Optional Feature:
CHAOS_UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits), held for div cycles.
  - Frame length becomes 11*div + 1 cycles.
- Undefined: no parity state, 8N1 only; the parity logic is absent from the netlist.

Test Plan:
- divisor=4, enable=1, push 0x55 -> tx low at cycle 1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high for 4 cycles. busy falls at cycle 41; the tbuart-style receiver reads 0x55.
- enable=0, push 9 bytes 0x00..0x08 back-to-back:
  - 8 accepted; fifo_count=8; data_ready=0; the 9th is held.
  - Set enable=1 -> first pop, data_ready=1, 0x08 accepted next edge.
  - 9 frames emitted in order, with 1 IDLE cycle between frames.
- divisor=0 and divisor=1 -> each bit lasts 2 cycles. Change divisor from 4 to 8 mid-frame -> current frame stays at 4, the next frame uses 8.
- Pull resetn low mid-DATA of 0xA3 -> tx=1 immediately, fifo_count=0, busy=0. After release, no residual frame is emitted.
- Deassert enable during DATA with 2 bytes queued -> the current frame finishes with a full stop bit, tx stays high, fifo_count=2. Reassert enable -> transmission resumes.
- With CHAOS_UART_TX_PARITY_EN, send 0x07 -> parity bit=1; send 0x03 -> parity bit=0. Frame length = 11*div + 1.
